fetch_sequencer: RTL and testbench

- Controller that sequences the 12-bit PC register unit. It drives `en_pc`, `en_new_pc` and `new_pc`, and reads `pc` back.
- Issues instruction-memory requests with a req/ack handshake and presents fetched words to decode with a valid/ready handshake.
- Applies redirect and halt/start control, and counts delivered instructions.
- Sits between the PC register, instruction memory and decode.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package fetch_pkg;

    localparam int DEF_PC_W    = 12;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        REQ    = 3'd2,
        DRAIN  = 3'd3,
        HOLD   = 3'd4,
        HALTED = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers the external PC register, issues instruction
// memory requests and hands fetched words to decode. Redirects rewrite the
// PC through its load port; halt stops fetching at an instruction boundary.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic [PC_W-1:0]    pc_i,
    output logic               en_pc,
    output logic               en_new_pc,
    output logic [PC_W-1:0]    new_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_e        state_r;
    fetch_state_e        state_s;
    logic [PC_W-1:0]     addr_r;
    logic [INSTR_W-1:0]  instr_data_r;
    logic [PC_W-1:0]     instr_pc_r;
    logic [CNT_W-1:0]    count_r;
    logic                capture_s;
    logic                deliver_s;
    logic                redirect_s;

    // A redirect only acts when reset is not overriding it.
    assign redirect_s = redirect_valid & ~reset;

    // Next-state selection; redirect outranks halt, which outranks normal flow.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        deliver_s = 1'b0;
        if (reset) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!redirect_s && start) begin
                        state_s = ISSUE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ISSUE: begin
                    if (redirect_s) begin
                        state_s = ISSUE;
                    end else if (halt) begin
                        state_s = HALTED;
                    end else begin
                        state_s = REQ;
                    end
                end
                REQ: begin
                    if (redirect_s) begin
                        // Outstanding request must still complete; its data is dropped.
                        if (imem_ack) begin
                            state_s = ISSUE;
                        end else begin
                            state_s = DRAIN;
                        end
                    end else if (imem_ack) begin
                        capture_s = 1'b1;
                        state_s   = HOLD;
                    end else begin
                        state_s = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_s = ISSUE;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect_s) begin
                        state_s = ISSUE;
                    end else if (instr_ready) begin
                        deliver_s = 1'b1;
                        if (halt) begin
                            state_s = HALTED;
                        end else begin
                            state_s = ISSUE;
                        end
                    end else begin
                        state_s = HOLD;
                    end
                end
                HALTED: begin
                    if (!redirect_s && !halt && start) begin
                        state_s = ISSUE;
                    end else begin
                        state_s = HALTED;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request address, held instruction and saturating delivery counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r       <= {PC_W{1'b0}};
            instr_data_r <= {INSTR_W{1'b0}};
            instr_pc_r   <= {PC_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
        end else begin
            if (state_r == ISSUE) begin
                addr_r <= pc_i;
            end
            if (capture_s) begin
                instr_data_r <= imem_rdata;
                instr_pc_r   <= addr_r;
            end
            if (deliver_s && (count_r != {CNT_W{1'b1}})) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // The PC register loads new_pc-1, so pre-bias the target by one.
    assign en_new_pc   = redirect_s;
    assign new_pc      = redirect_s ? (redirect_target + {{(PC_W-1){1'b0}}, 1'b1})
                                    : {PC_W{1'b0}};
    assign en_pc       = deliver_s;
    assign imem_req    = (state_r == REQ) || (state_r == DRAIN);
    assign imem_addr   = imem_req ? addr_r : {PC_W{1'b0}};
    assign instr_valid = (state_r == HOLD);
    assign instr_data  = instr_data_r;
    assign instr_pc    = instr_pc_r;
    assign busy        = (state_r != IDLE) && (state_r != HALTED);
    assign halted      = (state_r == HALTED);
    assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer, with a PC register,
// instruction memory and delivery-count model kept in the bench.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, halt, imem_ack, instr_ready, redirect_valid;
    logic [11:0] pc_reg, redirect_target;
    logic [15:0] imem_rdata;
    wire         en_pc, en_new_pc, imem_req, instr_valid, busy, halted;
    wire  [11:0] new_pc, imem_addr, instr_pc;
    wire  [15:0] instr_data, fetch_count;
    wire         en_pc4, en_new_pc4, imem_req4, instr_valid4, busy4, halted4;
    wire  [11:0] new_pc4, imem_addr4, instr_pc4;
    wire  [15:0] instr_data4;
    wire  [3:0]  fetch_count4;

    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_req_cyc = 0;
    int          t_first;
    logic [11:0] exp_pc;
    logic [15:0] exp_count;
    logic [3:0]  exp_count4;
    logic [15:0] mem_model [4096];

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .pc_i(pc_reg),
        .en_pc(en_pc), .en_new_pc(en_new_pc), .new_pc(new_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .busy(busy), .halted(halted),
        .fetch_count(fetch_count)
    );

    fetch_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .pc_i(pc_reg),
        .en_pc(en_pc4), .en_new_pc(en_new_pc4), .new_pc(new_pc4),
        .imem_req(imem_req4), .imem_addr(imem_addr4), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid4), .instr_ready(instr_ready),
        .instr_data(instr_data4), .instr_pc(instr_pc4), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .busy(busy4), .halted(halted4),
        .fetch_count(fetch_count4)
    );

    always #5 clk = ~clk;

    // PC register unit: increments on en_pc, loads new_pc-1 on en_new_pc.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) pc_reg <= 12'h000;
        else if (en_new_pc) pc_reg <= new_pc - 12'd1;
        else if (en_pc) pc_reg <= pc_reg + 12'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req();
        for (int n = 0; n < 10 && imem_req !== 1'b1; n++) tick();
        chk("req_seen", imem_req, 1);
        chk("req_addr", imem_addr, exp_pc);
        chk("req_busy", busy, 1);
        last_req_cyc = cyc;
    endtask

    task automatic ack_phase(input int delay, input logic [15:0] data);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("req_held", imem_req, 1);
            chk("req_addr_stable", imem_addr, exp_pc);
        end
        imem_ack = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic hold_phase(input int ready_delay, input logic [15:0] data);
        chk("hold_valid", instr_valid, 1);
        chk("hold_data", instr_data, data);
        chk("hold_pc", instr_pc, exp_pc);
        for (int i = 0; i < ready_delay; i++) begin
            instr_ready = 1'b0;
            #1;
            chk("no_en_pc_wait", en_pc, 0);
            tick();
            chk("valid_stable", instr_valid, 1);
            chk("data_stable", instr_data, data);
        end
        instr_ready = 1'b1;
        #1;
        chk("en_pc_pulse", en_pc, 1);
        chk("no_load_on_inc", en_new_pc, 0);
        tick();
        instr_ready = 1'b0;
        exp_count  = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
        exp_count4 = (exp_count4 == 4'hF) ? exp_count4 : exp_count4 + 4'd1;
        exp_pc     = exp_pc + 12'd1;
        chk("count", fetch_count, exp_count);
        chk("count4", fetch_count4, exp_count4);
        chk("valid_drop", instr_valid, 0);
        chk("en_pc_single", en_pc, 0);
        chk("pc_next", pc_reg, exp_pc);
    endtask

    task automatic fetch_one(input int ack_delay, input int ready_delay);
        logic [15:0] d;
        wait_req();
        d = mem_model[exp_pc];
        ack_phase(ack_delay, d);
        hold_phase(ready_delay, d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_pc = 12'h000;
        exp_count = 16'h0000;
        exp_count4 = 4'h0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = 16'($urandom);
        mem_model[0] = 16'h1234;
        reset = 1'b1; start = 1'b0; halt = 1'b0; imem_ack = 1'b0;
        imem_rdata = 16'h0000; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 12'h000;
        do_reset();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_en_pc", en_pc, 0);
        chk("rst_en_new_pc", en_new_pc, 0);
        chk("rst_new_pc", new_pc, 0);
        chk("rst_data", instr_data, 0);
        chk("rst_ipc", instr_pc, 0);
        chk("rst_count", fetch_count, 0);

        // First fetch, then a fetch where decode stalls for 5 cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("issue_no_req", imem_req, 0);
        fetch_one(0, 0);
        t_first = last_req_cyc;
        fetch_one(0, 5);
        chk("period", last_req_cyc - t_first, 3);

        // Redirect to 0x080 while the request at 0x002 waits for ack
        wait_req();
        redirect_valid = 1'b1;
        redirect_target = 12'h080;
        #1;
        chk("rd_en_new_pc", en_new_pc, 1);
        chk("rd_new_pc", new_pc, 12'h081);
        chk("rd_no_en_pc", en_pc, 0);
        tick();
        redirect_valid = 1'b0;
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 12'h002);
        chk("drain_pc", pc_reg, 12'h080);
        tick();
        chk("drain_addr2", imem_addr, 12'h002);
        imem_ack = 1'b1;
        imem_rdata = 16'hDEAD;
        tick();
        imem_ack = 1'b0;
        chk("drain_discard", instr_valid, 0);
        chk("drain_done", imem_req, 0);
        exp_pc = 12'h080;
        fetch_one(0, 0);

        // Redirect to 0xFFF coinciding with the decode handshake
        wait_req();
        ack_phase(0, mem_model[exp_pc]);
        chk("hs_valid", instr_valid, 1);
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 12'hFFF;
        #1;
        chk("wrap_new_pc", new_pc, 12'h000);
        chk("wrap_en_new_pc", en_new_pc, 1);
        chk("wrap_no_en_pc", en_pc, 0);
        tick();
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("wrap_valid_drop", instr_valid, 0);
        chk("wrap_count", fetch_count, exp_count);
        chk("wrap_pc", pc_reg, 12'hFFF);
        exp_pc = 12'hFFF;
        fetch_one(1, 0);
        chk("pc_wrapped", pc_reg, 12'h000);

        // Halt raised during REQ: the fetch is still delivered, then HALTED
        wait_req();
        halt = 1'b1;
        ack_phase(1, mem_model[exp_pc]);
        hold_phase(0, mem_model[exp_pc - 12'd0]);
        chk("halted", halted, 1);
        chk("halted_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halted_no_req", imem_req, 0);
        end
        start = 1'b1;
        tick();
        chk("halt_beats_start", halted, 1);
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 12'h200;
        #1;
        chk("halted_rd", en_new_pc, 1);
        tick();
        redirect_valid = 1'b0;
        chk("halted_rd_state", halted, 1);
        chk("halted_rd_pc", pc_reg, 12'h200);
        exp_pc = 12'h200;
        halt = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume", halted, 0);
        fetch_one(0, 1);

        // Reset with a request outstanding, then a stray ack
        wait_req();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pc = 12'h000;
        exp_count = 16'h0000;
        exp_count4 = 4'h0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_count", fetch_count, 0);
        chk("mid_rst_data", instr_data, 0);
        imem_ack = 1'b1;
        imem_rdata = 16'hBEEF;
        #1;
        chk("stray_no_en_pc", en_pc, 0);
        tick();
        imem_ack = 1'b0;
        chk("stray_req", imem_req, 0);
        chk("stray_valid", instr_valid, 0);
        chk("stray_busy", busy, 0);
        chk("stray_data", instr_data, 0);

        // Randomized latencies; 20 deliveries saturate the 4-bit counter
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        chk("sat4", fetch_count4, 4'hF);
        chk("count20", fetch_count, 16'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
